// File: rtl/demo_scene_sequencer.sv
// Scene scheduler: counts vsync frames and walks vga_state/audio_select through the scene loop.
// Optional fade gap between scenes is enabled with the SCENE_FADE_EN macro.
module demo_scene_sequencer #(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_FRAMES = 120,
  parameter int FADE_FRAMES  = 8,
  parameter int FRAME_CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       skip,
  input  logic       pause,
  output logic [1:0] vga_state,
  output logic [1:0] audio_select,
  output logic       scene_blank,
  output logic       frame_tick
);

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    FADE = 1'b1
  } state_t;

  localparam logic [1:0]             LAST_IDX   = 2'(NUM_SCENES - 1);
  localparam logic [FRAME_CNT_W-1:0] SCENE_LAST = FRAME_CNT_W'(SCENE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] FADE_LAST  = FRAME_CNT_W'(FADE_FRAMES - 1);

  state_t                 state_r;
  logic                   vsync_q_r;
  logic                   skip_meta_r;
  logic                   skip_sync_r;
  logic                   skip_prev_r;
  logic [1:0]             scene_idx_r;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;

  logic [1:0]             next_idx_s;
  logic                   skip_pulse_s;
  logic                   count_en_s;
  logic                   scene_end_s;
  logic                   fade_end_s;

  // Frame detect: one-cycle pulse on the first sampled low vsync cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q_r  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vsync_q_r  <= vsync;
      frame_tick <= vsync_q_r & ~vsync;
    end
  end

  // Skip button synchroniser plus edge register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_meta_r <= 1'b0;
      skip_sync_r <= 1'b0;
      skip_prev_r <= 1'b0;
    end else begin
      skip_meta_r <= skip;
      skip_sync_r <= skip_meta_r;
      skip_prev_r <= skip_sync_r;
    end
  end

  // Next-scene and end-of-interval decode.
  always_comb begin
    next_idx_s   = (scene_idx_r == LAST_IDX) ? 2'd0 : scene_idx_r + 2'd1;
    skip_pulse_s = skip_sync_r & ~skip_prev_r;
    count_en_s   = frame_tick & ~pause;
    // Skip bypasses pause; a coincident expiry still yields a single end.
    scene_end_s  = skip_pulse_s | (count_en_s & (frame_cnt_r == SCENE_LAST));
    fade_end_s   = skip_pulse_s | (count_en_s & (frame_cnt_r == FADE_LAST));
  end

  // Scene FSM with registered output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= PLAY;
      scene_idx_r  <= 2'd0;
      frame_cnt_r  <= '0;
      vga_state    <= 2'd0;
      audio_select <= 2'd1;
      scene_blank  <= 1'b0;
    end else begin
      case (state_r)
        PLAY: begin
          if (scene_end_s) begin
            frame_cnt_r <= '0;
`ifdef SCENE_FADE_EN
            state_r     <= FADE;
            scene_blank <= 1'b1;
`else
            scene_idx_r  <= next_idx_s;
            vga_state    <= next_idx_s;
            audio_select <= next_idx_s + 2'd1;
            scene_blank  <= 1'b0;
`endif
          end else if (count_en_s) begin
            frame_cnt_r <= frame_cnt_r + 1'b1;
          end
        end
        FADE: begin
          if (fade_end_s) begin
            state_r      <= PLAY;
            frame_cnt_r  <= '0;
            scene_idx_r  <= next_idx_s;
            vga_state    <= next_idx_s;
            audio_select <= next_idx_s + 2'd1;
            scene_blank  <= 1'b0;
          end else if (count_en_s) begin
            frame_cnt_r <= frame_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r     <= PLAY;
          frame_cnt_r <= '0;
          scene_blank <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Directed bench for demo_scene_sequencer with SCENE_FRAMES=3, FADE_FRAMES=2, NUM_SCENES=4.
// Define SCENE_FADE_EN for both DUT and bench to exercise the fade build.
module tb_demo_scene_sequencer;

  logic       clk;
  logic       rst;
  logic       vsync;
  logic       skip;
  logic       pause;
  logic [1:0] vga_state;
  logic [1:0] audio_select;
  logic       scene_blank;
  logic       frame_tick;

  int checks;
  int errors;
  int tick_cnt;
  int tick_base;

  demo_scene_sequencer #(
    .NUM_SCENES  (4),
    .SCENE_FRAMES(3),
    .FADE_FRAMES (2),
    .FRAME_CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .skip        (skip),
    .pause       (pause),
    .vga_state   (vga_state),
    .audio_select(audio_select),
    .scene_blank (scene_blank),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with frame_tick high, sampled on the inactive edge.
  always @(negedge clk) begin
    if (frame_tick) tick_cnt = tick_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    vsync = 1'b0;
    step(2);
    vsync = 1'b1;
    step(4);
  endtask

  task automatic send_frames(input int n);
    for (int k = 0; k < n; k++) send_frame();
  endtask

  task automatic press_skip();
    skip = 1'b1;
    step(3);
    skip = 1'b0;
    step(4);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    tick_cnt = 0;
    rst      = 1'b1;
    vsync    = 1'b1;
    skip     = 1'b0;
    pause    = 1'b0;
    step(3);
    check_val("rst_vga", {30'd0, vga_state}, 32'd0);
    check_val("rst_audio", {30'd0, audio_select}, 32'd1);
    check_val("rst_blank", {31'd0, scene_blank}, 32'd0);
    check_val("rst_tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    step(2);

`ifndef SCENE_FADE_EN
    // Free run: advance every 3 ticks, wrap after scene 3.
    tick_base = tick_cnt;
    for (int i = 1; i <= 12; i++) begin
      send_frame();
      check_val($sformatf("run_vga_%0d", i), {30'd0, vga_state}, 32'((i / 3) % 4));
      check_val($sformatf("run_audio_%0d", i), {30'd0, audio_select}, 32'(((i / 3) + 1) % 4));
      check_val($sformatf("run_blank_%0d", i), {31'd0, scene_blank}, 32'd0);
    end
    check_val("run_tick_cycles", 32'(tick_cnt - tick_base), 32'd12);

    // Skip held 50 cycles at frame_cnt=1: one advance on the 3rd edge.
    send_frame();
    skip = 1'b1;
    step(2);
    check_val("skip_before", {30'd0, vga_state}, 32'd0);
    step(1);
    check_val("skip_third_edge", {30'd0, vga_state}, 32'd1);
    check_val("skip_audio", {30'd0, audio_select}, 32'd2);
    step(47);
    check_val("skip_held", {30'd0, vga_state}, 32'd1);
    skip = 1'b0;
    step(4);
    send_frames(2);
    check_val("skip_cnt_reset", {30'd0, vga_state}, 32'd1);
    send_frame();
    check_val("skip_next_adv", {30'd0, vga_state}, 32'd2);

    // Pause at frame_cnt=1 for 10 frames, then resume.
    send_frame();
    pause = 1'b1;
    send_frames(10);
    check_val("pause_hold", {30'd0, vga_state}, 32'd2);
    pause = 1'b0;
    send_frame();
    check_val("pause_resume1", {30'd0, vga_state}, 32'd2);
    send_frame();
    check_val("pause_resume2", {30'd0, vga_state}, 32'd3);
    pause = 1'b1;
    press_skip();
    check_val("pause_skip", {30'd0, vga_state}, 32'd0);
    check_val("pause_skip_aud", {30'd0, audio_select}, 32'd1);
    pause = 1'b0;

    // Skip pulse coincident with the expiring 3rd tick.
    send_frames(2);
    check_val("simul_pre", {30'd0, vga_state}, 32'd0);
    skip = 1'b1;
    step(1);
    vsync = 1'b0;
    step(1);
    check_val("simul_tick", {31'd0, frame_tick}, 32'd1);
    step(1);
    check_val("simul_single", {30'd0, vga_state}, 32'd1);
    vsync = 1'b1;
    step(4);
    check_val("simul_settled", {30'd0, vga_state}, 32'd1);
    skip = 1'b0;
    step(4);
    send_frames(2);
    check_val("simul_cnt0", {30'd0, vga_state}, 32'd1);
    send_frame();
    check_val("simul_next", {30'd0, vga_state}, 32'd2);
`else
    // Fade build: 3 ticks enter fade, 2 ticks leave it, skip cuts it short.
    send_frames(3);
    check_val("fade_blank", {31'd0, scene_blank}, 32'd1);
    check_val("fade_vga_hold", {30'd0, vga_state}, 32'd0);
    send_frame();
    check_val("fade_mid", {31'd0, scene_blank}, 32'd1);
    send_frame();
    check_val("fade_done_vga", {30'd0, vga_state}, 32'd1);
    check_val("fade_done_blank", {31'd0, scene_blank}, 32'd0);
    check_val("fade_done_aud", {30'd0, audio_select}, 32'd2);
    send_frames(3);
    check_val("fade2_blank", {31'd0, scene_blank}, 32'd1);
    skip = 1'b1;
    step(3);
    check_val("fade_skip_vga", {30'd0, vga_state}, 32'd2);
    check_val("fade_skip_blank", {31'd0, scene_blank}, 32'd0);
    skip = 1'b0;
    step(4);
    send_frames(3);
`endif

    // Drive to scene 2, then reset asynchronously while a tick is high.
    while (vga_state != 2'd2 && checks < 1000) begin
      send_frame();
      checks = checks + 1;
      if (checks >= 1000) begin
        errors = errors + 1;
        $display("FAIL reach_scene2: got %0d expected 2", vga_state);
      end
    end
    vsync = 1'b0;
    step(1);
    check_val("mid_tick_high", {31'd0, frame_tick}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_vga", {30'd0, vga_state}, 32'd0);
    check_val("mid_rst_audio", {30'd0, audio_select}, 32'd1);
    check_val("mid_rst_blank", {31'd0, scene_blank}, 32'd0);
    check_val("mid_rst_tick", {31'd0, frame_tick}, 32'd0);
    vsync = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
